// File: rtl/cla4_clk.sv
// rtl/cla4_clk.sv - registered 4-bit carry-lookahead adder
// Operands registered, lookahead carries formed in parallel, sum/carry registered.
module cla4_clk (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] a_q, b_q;
  logic       ci_q;
  logic [3:0] s_q;
  logic       co_q;

  logic [3:0] g, p;
  logic [4:0] c;
  logic [3:0] sum_d;
  logic       co_d;

  assign g = a_q & b_q;
  assign p = a_q ^ b_q;

  // Every carry is a flat sum of products of g/p and ci_q; none reuses a lower carry.
  assign c[0] = ci_q;
  assign c[1] = g[0] | (p[0] & ci_q);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_q);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci_q);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci_q);

  assign sum_d = p ^ c[3:0];
  assign co_d  = c[4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q  <= 4'b0000;
      b_q  <= 4'b0000;
      ci_q <= 1'b0;
      s_q  <= 4'b0000;
      co_q <= 1'b0;
    end else begin
      a_q  <= a;
      b_q  <= b;
      ci_q <= ci;
      s_q  <= sum_d;
      co_q <= co_d;
    end
  end

  assign s  = s_q;
  assign co = co_q;

endmodule

// File: tb/tb_cla4_clk.sv
// tb/tb_cla4_clk.sv - directed self-checking bench for cla4_clk
module tb_cla4_clk;

  logic       clk;
  logic       reset_n;
  logic [3:0] a, b;
  logic       ci;
  logic [3:0] s;
  logic       co;

  int total = 0;
  int bad   = 0;

  cla4_clk dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (a),
    .b       (b),
    .ci      (ci),
    .s       (s),
    .co      (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic run_vec(input string tag, input logic [3:0] va, input logic [3:0] vb,
                         input logic vci, input logic [4:0] exp);
    a = va; b = vb; ci = vci;
    @(posedge clk);
    @(posedge clk);
    #1;
    check(tag, {co, s}, exp);
  endtask

  logic [3:0] pa   [8] = '{4'd2, 4'd9, 4'd15, 4'd4, 4'd0, 4'd7, 4'd10, 4'd6};
  logic [3:0] pb   [8] = '{4'd3, 4'd9, 4'd1, 4'd4, 4'd15, 4'd8, 4'd5, 4'd3};
  logic       pci  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [4:0] pexp [8] = '{5'd5, 5'd18, 5'd16, 5'd9, 5'd16, 5'd15, 5'd16, 5'd9};

  logic [4:0] exh_exp [512];

  initial begin
    reset_n = 1'b0;
    a = 4'hF; b = 4'hF; ci = 1'b1;
    #1;
    check("reset_initial", {co, s}, 5'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_hold", {co, s}, 5'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("reset_release_edge1", {co, s}, 5'd0);
    @(posedge clk); #1;
    check("reset_release_edge2", {co, s}, 5'd31);

    run_vec("add_0_0",      4'd0,  4'd0,  1'b0, 5'b00000);
    run_vec("add_1_3",      4'd1,  4'd3,  1'b0, 5'b00100);
    run_vec("add_8_7",      4'd8,  4'd7,  1'b0, 5'b01111);
    run_vec("add_12_5",     4'd12, 4'd5,  1'b0, 5'b10001);
    run_vec("add_15_15",    4'd15, 4'd15, 1'b0, 5'b11110);
    run_vec("add_1_7_ci",   4'd1,  4'd7,  1'b1, 5'b01001);
    run_vec("add_8_8_ci",   4'd8,  4'd8,  1'b1, 5'b10001);
    run_vec("add_15_0_ci",  4'd15, 4'd0,  1'b1, 5'b10000);

    // One operand set per cycle; the result of iteration i-1 is visible after this edge.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        a = pa[i]; b = pb[i]; ci = pci[i];
      end
      @(posedge clk); #1;
      if (i >= 1) check("pipe", {co, s}, pexp[i-1]);
    end

    a = 4'd8; b = 4'd8; ci = 1'b1;
    @(posedge clk); #1;
    a = 4'd15; b = 4'd15; ci = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_result", {co, s}, 5'd17);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_immediate", {co, s}, 5'd0);
    a = 4'd3; b = 4'd4; ci = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("reset_no_30", {co, s}, 5'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_edge1", {co, s}, 5'd0);
    @(posedge clk); #1;
    check("post_reset_edge2", {co, s}, 5'd7);

    for (int i = 0; i < 512; i++) exh_exp[i] = 5'((i >> 5) + ((i >> 1) & 15) + (i & 1));
    for (int i = 0; i <= 512; i++) begin
      if (i < 512) begin
        a = 4'(i >> 5); b = 4'((i >> 1) & 15); ci = 1'(i & 1);
      end
      @(posedge clk); #1;
      if (i >= 1) check("exhaustive", {co, s}, exh_exp[i-1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla4_clk.md
# cla4_clk

Registered 4-bit carry-lookahead adder. It computes `{co, s} = a + b + ci` through a single-level lookahead carry network, with all carries formed in parallel from generate/propagate terms. Operands are captured in an input register stage and the result is captured in an output register stage. It is the clocked leaf adder for wider datapaths and the timing-closure variant of the combinational 4-bit CLA.

## Interface
- No parameters; width fixed at 4 bits.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset; clears every register.
- `a`  input  4  operand A, unsigned.
- `b`  input  4  operand B, unsigned.
- `ci`  input  1  carry-in.
- `s`  output  4  registered sum bits.
- `co`  output  1  registered carry-out (bit 4 of the 5-bit result).

## Operation
- Stage 1 (input register):
  - `a_r`, `b_r` and `ci_r` load `a`, `b` and `ci` on every rising `clk`.
  - There is no enable; the stage captures every cycle.
- Combinational core, operating on the stage-1 registers:
  - Per-bit generate: `g[i] = a_r[i] & b_r[i]`.
  - Per-bit propagate: `p[i] = a_r[i] ^ b_r[i]`.
  - c0 = ci_r.
  - c1 = g0 | p0·c0.
  - c2 = g1 | p1·g0 | p1·p0·c0.
  - c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·c0.
  - c4 = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 | p3·p2·p1·p0·c0.
  - Sum: `sum[i] = p[i] ^ c[i]`.
  - No carry may be derived from a lower carry (no ripple chain).
- Stage 2 (output register):
  - `s` loads `sum[3:0]` and `co` loads `c4` on every rising `clk`.
- Arithmetic:
  - Unsigned; the 5-bit result `{co, s}` ranges 0..31.
  - No overflow flag; `co` is the only overflow indication.
- Reset:
  - `reset_n` low immediately, without waiting for `clk`, clears `a_r`, `b_r`, `ci_r`, `s` and `co` to 0.
  - Registers hold 0 while `reset_n` is low.
  - Normal capture resumes on the first rising `clk` after `reset_n` goes high.
  - If reset is asserted while a result is in flight, that result is discarded.
- There is no handshake or valid signal. Consumers count latency themselves.

## Timing
- Latency is 2 rising edges:
  - Inputs present before edge N are captured at edge N.
  - The result appears on `s`/`co` after edge N+1.
- Throughput is one new operand set per cycle, fully pipelined.
- Outputs change only on a `clk` edge or on the assertion of `reset_n`. They never glitch with input changes.
- Critical path: stage-1 register → g/p → c4 (two-level AND-OR) → sum XOR → stage-2 register.
- Reset value of `s` is 4'b0000; reset value of `co` is 0.
- Inputs changing between edges have no effect until the next edge. Only the value at the edge counts.

## Test plan
- Reset:
  - Stimulus: drive `reset_n=0` with `a=4'hF`, `b=4'hF`, `ci=1`, and toggle `clk`.
  - Required: `s=0`, `co=0` throughout. The first valid result appears 2 edges after `reset_n` rises.
- Basic sums with `ci=0`, each checked 2 edges after its inputs are applied:
  - 0+0 → `{co,s}`=00000.
  - 1+3 → 00100.
  - 8+7 → 01111.
- Carry-out with `ci=0`:
  - 12+5 (1100+0101) → 10001.
  - 15+15 → 11110.
- Carry-in `ci=1`:
  - 1+7+1 → 01001.
  - 8+8+1 → 10001.
  - 15+0+1 → 10000, which exercises the full propagate chain into c4.
- Pipelining:
  - Stimulus: apply a new operand pair every cycle for 8 cycles.
  - Required: the output stream matches the input stream delayed by exactly 2 cycles, with no bubbles.
- Mid-operation reset plus exhaustive check:
  - Assert `reset_n=0` asynchronously between edges with 15+15 in flight. Required: outputs go to 0 immediately, and the value 30 never appears.
  - Then run all 512 combinations of `a`, `b`, `ci` and compare each result against `a+b+ci`.
